// File: rtl/pm_pkg.sv
// pm_pkg: shared encodings for the SERV sleep/wake sequencer.
// State codes, register offsets, CTRL bit positions, delay defaults.
package pm_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_GUARD  = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_SETTLE = 2'd3
  } pm_state_e;

  localparam logic [1:0] PM_CTRL   = 2'd0;
  localparam logic [1:0] PM_MASK   = 2'd1;
  localparam logic [1:0] PM_STATUS = 2'd2;
  localparam logic [1:0] PM_DELAY  = 2'd3;

  localparam int CTRL_SLEEP = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_TMO   = 3;

  localparam logic [15:0] GUARD_RST  = 16'd16;
  localparam logic [15:0] SETTLE_RST = 16'd16;

endpackage

// File: rtl/pm_wake_sync.sv
// pm_wake_sync: wake-line synchronizer feeding a sticky STATUS register.
// A synchronized set beats a W1C clear on the same bit.
module pm_wake_sync #(
  parameter int N_WAKE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_WAKE-1:0] i_wake,
  input  logic [N_WAKE-1:0] i_clr,
  output logic [N_WAKE-1:0] o_status
);

  logic [SYNC_STAGES-1:0][N_WAKE-1:0] sync_q;
  logic [N_WAKE-1:0]                  status_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q   <= '0;
      status_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], i_wake};
      status_q <= (status_q & ~i_clr) | sync_q[SYNC_STAGES-1];
    end
  end

  assign o_status = status_q;

endmodule

// File: rtl/pm_sleep_ctrl_wb.sv
// pm_sleep_ctrl_wb: Wishbone sleep/wake sequencer driving the core clock gate.
// Optional sleep timeout enabled by defining PM_SLEEP_TIMEOUT_EN.
module pm_sleep_ctrl_wb
  import pm_pkg::*;
#(
  parameter int          N_WAKE      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned MAX_SLEEP   = 2**20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_WAKE-1:0] i_wake,
  output logic              o_clk_en,
  output logic              o_core_ready,
  output logic              o_wake_irq,
  input  logic [31:0]       i_wb_pm_adr,
  input  logic [31:0]       i_wb_pm_dat,
  input  logic              i_wb_pm_we,
  input  logic              i_wb_pm_cyc,
  output logic [31:0]       o_wb_pm_rdt,
  output logic              o_wb_pm_ack
);

  logic              ack_q;
  logic [31:0]       rdt_q;
  logic [31:0]       rdata;
  logic              acc;
  logic              wr;
  logic              rd;
  logic [1:0]        reg_sel;
  logic [N_WAKE-1:0] mask_q;
  logic [N_WAKE-1:0] status;
  logic [N_WAKE-1:0] clr;
  logic [15:0]       guard_q;
  logic [15:0]       settle_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  pm_state_e         state_q;
  pm_state_e         state_d;
  logic              abort_q;
  logic              abort_d;
  logic              tmo_q;
  logic              tmo_d;
  logic              irq_q;
  logic              irq_d;
  logic              strobe;
  logic              clr_flags;
  logic              pend;
  logic              tmo_hit;

  assign acc       = i_wb_pm_cyc & ~ack_q;
  assign wr        = acc & i_wb_pm_we;
  assign rd        = acc & ~i_wb_pm_we;
  assign reg_sel   = i_wb_pm_adr[3:2];
  assign strobe    = wr && (reg_sel == PM_CTRL) && i_wb_pm_dat[CTRL_SLEEP];
  assign clr_flags = wr && (reg_sel == PM_CTRL) && i_wb_pm_dat[CTRL_CLR];
  assign clr       = (wr && (reg_sel == PM_STATUS)) ? i_wb_pm_dat[N_WAKE-1:0] : '0;
  assign pend      = |(status & mask_q);

  pm_wake_sync #(
    .N_WAKE      (N_WAKE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wake_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wake   (i_wake),
    .i_clr    (clr),
    .o_status (status)
  );

`ifdef PM_SLEEP_TIMEOUT_EN
  logic [19:0] scnt_q;

  // Restarts from zero on every SLEEP entry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      scnt_q <= '0;
    else if (state_q != ST_SLEEP)
      scnt_q <= '0;
    else
      scnt_q <= scnt_q + 20'd1;
  end

  assign tmo_hit = (scnt_q == 20'(MAX_SLEEP - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = clr_flags ? 1'b0 : abort_q;
    tmo_d   = clr_flags ? 1'b0 : tmo_q;
    irq_d   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (strobe && pend) begin
          abort_d = 1'b1;
        end else if (strobe) begin
          state_d = ST_GUARD;
          cnt_d   = guard_q;
        end
      end
      ST_GUARD: begin
        if (pend) begin
          state_d = ST_RUN;
          abort_d = 1'b1;
        end else if (cnt_q == 16'd0) begin
          state_d = ST_SLEEP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SLEEP: begin
        if (pend || tmo_hit) begin
          state_d = ST_SETTLE;
          cnt_d   = settle_q;
        end
        if (tmo_hit) tmo_d = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_RUN;
          irq_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      PM_CTRL: begin
        rdata[1:0]       = state_q;
        rdata[CTRL_ABORT] = abort_q;
        rdata[CTRL_TMO]  = tmo_q;
      end
      PM_MASK:   rdata[N_WAKE-1:0] = mask_q;
      PM_STATUS: rdata[N_WAKE-1:0] = status;
      PM_DELAY:  rdata = {settle_q, guard_q};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      mask_q   <= '0;
      guard_q  <= GUARD_RST;
      settle_q <= SETTLE_RST;
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      tmo_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q   <= acc;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      tmo_q   <= tmo_d;
      irq_q   <= irq_d;
      if (rd) rdt_q <= rdata;
      if (wr && (reg_sel == PM_MASK))
        mask_q <= i_wb_pm_dat[N_WAKE-1:0];
      if (wr && (reg_sel == PM_DELAY)) begin
        guard_q  <= i_wb_pm_dat[15:0];
        settle_q <= i_wb_pm_dat[31:16];
      end
    end
  end

  assign o_clk_en     = (state_q != ST_SLEEP);
  assign o_core_ready = (state_q == ST_RUN);
  assign o_wake_irq   = irq_q;
  assign o_wb_pm_ack  = ack_q;
  assign o_wb_pm_rdt  = rdt_q;

  logic unused_ok;
  assign unused_ok = ^{i_wb_pm_adr[31:4], i_wb_pm_adr[1:0], MAX_SLEEP[0]};

endmodule
